// File: rtl/axi_time_core.sv
// axi_time_core: time-domain timestamp counter with overwrite, RX/TX match
// triggers, capture strobes, underrun detection and optional external sync.
module axi_time_core #(
  parameter int COUNT_WIDTH       = 64,
  parameter int SYNC_EXTERNAL     = 0,
  parameter int SYNC_EXTERNAL_CDC = 0
) (
  input  logic                   time_clk,
  input  logic                   time_resetn,
  input  logic                   time_enable,
  input  logic                   time_sync_ext,
  input  logic                   time_sync_soft,
  input  logic                   time_sync_in,
  input  logic [COUNT_WIDTH-1:0] time_overwrite,
  input  logic                   time_overwrite_valid,
  output logic                   time_overwrite_ready,
  input  logic [COUNT_WIDTH-1:0] time_rx_trigger,
  input  logic                   time_rx_trigger_valid,
  output logic                   time_rx_trigger_ready,
  input  logic [COUNT_WIDTH-1:0] time_tx_trigger,
  input  logic                   time_tx_trigger_valid,
  output logic                   time_tx_trigger_ready,
  output logic [COUNT_WIDTH-1:0] time_rx_capture,
  output logic                   time_rx_capture_valid,
  output logic [COUNT_WIDTH-1:0] time_tx_capture,
  output logic                   time_tx_capture_valid,
  output logic                   time_running_rx,
  output logic                   time_running_tx,
  output logic                   time_underrun_rx,
  output logic                   time_underrun_tx,
  output logic [COUNT_WIDTH-1:0] time_counter,
  output logic                   time_rx_fire,
  output logic                   time_tx_fire
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   sync_lvl;
  logic                   sync_d;
  logic                   sync_edge;
  logic                   sync_event;
  logic                   ext_sync_mode;
  logic                   ow_ready;
  logic                   ow_load;
  logic [COUNT_WIDTH-1:0] counter;
  logic                   rx_pending;
  logic                   tx_pending;
  logic [COUNT_WIDTH-1:0] rx_slot;
  logic [COUNT_WIDTH-1:0] tx_slot;
  logic                   rx_accept;
  logic                   tx_accept;
  logic                   rx_match;
  logic                   tx_match;
  logic                   rx_late;
  logic                   tx_late;

  logic                   rx_fire_p1;
  logic                   tx_fire_p1;
  logic                   rx_cap_vld_p1;
  logic                   tx_cap_vld_p1;
  logic [COUNT_WIDTH-1:0] rx_cap_p1;
  logic [COUNT_WIDTH-1:0] tx_cap_p1;
  logic                   rx_underrun_p1;
  logic                   tx_underrun_p1;
  logic                   rx_running_p1;
  logic                   tx_running_p1;

  generate
    if (SYNC_EXTERNAL_CDC != 0) begin : g_sync_cdc
      logic sync_m1;
      logic sync_m2;
      // Two-flop synchronizer for the asynchronous external sync input
      always_ff @(posedge time_clk or negedge time_resetn) begin
        if (!time_resetn) begin
          sync_m1 <= 1'b0;
          sync_m2 <= 1'b0;
        end else begin
          sync_m1 <= time_sync_in;
          sync_m2 <= sync_m1;
        end
      end
      assign sync_lvl = sync_m2;
    end else begin : g_sync_direct
      assign sync_lvl = time_sync_in;
    end
  endgenerate

  // Previous sync level for rising-edge detection
  always_ff @(posedge time_clk or negedge time_resetn) begin
    if (!time_resetn) begin
      sync_d <= 1'b0;
    end else begin
      sync_d <= sync_lvl;
    end
  end

  assign sync_edge     = sync_lvl && !sync_d;
  assign ext_sync_mode = (SYNC_EXTERNAL != 0) && time_sync_ext;
  // Soft and external events arriving together collapse into one event.
  assign sync_event    = time_sync_soft || ((SYNC_EXTERNAL != 0) && sync_edge);

  assign ow_load   = time_overwrite_valid && ow_ready;
  assign rx_accept = time_rx_trigger_valid && time_rx_trigger_ready;
  assign tx_accept = time_tx_trigger_valid && time_tx_trigger_ready;

  // Match/underrun use the pre-load counter so a same-cycle overwrite never masks a fire.
  assign rx_match = (state == RUN) && rx_pending && (counter == rx_slot);
  assign tx_match = (state == RUN) && tx_pending && (counter == tx_slot);
  assign rx_late  = (state == RUN) && rx_pending && (counter > rx_slot);
  assign tx_late  = (state == RUN) && tx_pending && (counter > tx_slot);

  // State register
  always_ff @(posedge time_clk or negedge time_resetn) begin
    if (!time_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: enable gates everything, sync events only matter before RUN
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (time_enable) begin
          if (time_sync_soft)     state_next = RUN;
          else if (ext_sync_mode) state_next = WAIT_SYNC;
          else                    state_next = RUN;
        end
      end
      WAIT_SYNC: begin
        if (!time_enable)    state_next = IDLE;
        else if (sync_event) state_next = RUN;
      end
      RUN: begin
        if (!time_enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Timestamp counter: load beats increment, counts only in RUN, wraps naturally
  always_ff @(posedge time_clk or negedge time_resetn) begin
    if (!time_resetn) begin
      counter  <= '0;
      ow_ready <= 1'b0;
    end else begin
      ow_ready <= 1'b1;
      if (ow_load) begin
        counter <= time_overwrite;
      end else if (state == RUN) begin
        counter <= counter + COUNT_WIDTH'(1);
      end
    end
  end

  // RX/TX pending slots: dropping to IDLE discards an armed trigger silently
  always_ff @(posedge time_clk or negedge time_resetn) begin
    if (!time_resetn) begin
      rx_pending <= 1'b0;
      tx_pending <= 1'b0;
      rx_slot    <= '0;
      tx_slot    <= '0;
    end else begin
      if (state_next == IDLE || rx_match || rx_late) begin
        rx_pending <= 1'b0;
      end else if (rx_accept) begin
        rx_pending <= 1'b1;
      end
      if (state_next == IDLE || tx_match || tx_late) begin
        tx_pending <= 1'b0;
      end else if (tx_accept) begin
        tx_pending <= 1'b1;
      end
      if (rx_accept) rx_slot <= time_rx_trigger;
      if (tx_accept) tx_slot <= time_tx_trigger;
    end
  end

  // ---- stage p1: registered fire, capture, underrun and running status ----
  always_ff @(posedge time_clk or negedge time_resetn) begin
    if (!time_resetn) begin
      rx_fire_p1     <= 1'b0;
      tx_fire_p1     <= 1'b0;
      rx_cap_vld_p1  <= 1'b0;
      tx_cap_vld_p1  <= 1'b0;
      rx_cap_p1      <= '0;
      tx_cap_p1      <= '0;
      rx_underrun_p1 <= 1'b0;
      tx_underrun_p1 <= 1'b0;
      rx_running_p1  <= 1'b0;
      tx_running_p1  <= 1'b0;
    end else begin
      rx_fire_p1     <= rx_match;
      tx_fire_p1     <= tx_match;
      rx_cap_vld_p1  <= rx_match;
      tx_cap_vld_p1  <= tx_match;
      if (rx_match) rx_cap_p1 <= rx_slot;
      if (tx_match) tx_cap_p1 <= tx_slot;
      rx_underrun_p1 <= rx_late;
      tx_underrun_p1 <= tx_late;
      rx_running_p1  <= rx_pending && (state == RUN);
      tx_running_p1  <= tx_pending && (state == RUN);
    end
  end

  assign time_overwrite_ready  = ow_ready;
  assign time_rx_trigger_ready = !rx_pending && (state != IDLE);
  assign time_tx_trigger_ready = !tx_pending && (state != IDLE);
  assign time_counter          = counter;
  assign time_rx_fire          = rx_fire_p1;
  assign time_tx_fire          = tx_fire_p1;
  assign time_rx_capture       = rx_cap_p1;
  assign time_tx_capture       = tx_cap_p1;
  assign time_rx_capture_valid = rx_cap_vld_p1;
  assign time_tx_capture_valid = tx_cap_vld_p1;
  assign time_underrun_rx      = rx_underrun_p1;
  assign time_underrun_tx      = tx_underrun_p1;
  assign time_running_rx       = rx_running_p1;
  assign time_running_tx       = tx_running_p1;

endmodule
